// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared types for the MEM stage.
// Memory op codes, FSM states, stall levels and op decode.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  localparam logic STOP      = 1'b1;
  localparam logic NOSTOP    = 1'b0;
  localparam int   STALL_MEM = 4;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic misaligned;
  } op_info_t;

  function automatic op_info_t decode_op(
    input logic [3:0] op,
    input logic [1:0] lo
  );
    op_info_t r;
    r = '0;
    case (mem_op_e'(op))
      OP_LB, OP_LBU: r.is_load = 1'b1;
      OP_LH, OP_LHU: begin
        r.is_load    = 1'b1;
        r.misaligned = lo[0];
      end
      OP_LW: begin
        r.is_load    = 1'b1;
        r.misaligned = |lo;
      end
      OP_SB: r.is_store = 1'b1;
      OP_SH: begin
        r.is_store   = 1'b1;
        r.misaligned = lo[0];
      end
      OP_SW: begin
        r.is_store   = 1'b1;
        r.misaligned = |lo;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane steering for the data bus.
// Load extract/extend and store byte-select/replication.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] ldata_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o
);

  mem_op_e     op;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;

  assign op   = mem_op_e'(op_i);
  assign rh   = lane_i[1] ? rdata_i[31:16]
                          : rdata_i[15:0];
  assign sz_b = (op == OP_LB) || (op == OP_LBU)
             || (op == OP_SB);
  assign sz_h = (op == OP_LH) || (op == OP_LHU)
             || (op == OP_SH);
  assign sz_w = (op == OP_LW) || (op == OP_SW);

  // Pick the addressed byte out of the read word.
  always_comb begin
    rb = rdata_i[7:0];
    case (lane_i)
      2'd0:    rb = rdata_i[7:0];
      2'd1:    rb = rdata_i[15:8];
      2'd2:    rb = rdata_i[23:16];
      default: rb = rdata_i[31:24];
    endcase
  end

  // Sign or zero extend the selected load data.
  always_comb begin
    ldata_o = rdata_i;
    case (op)
      OP_LB:   ldata_o = {{24{rb[7]}}, rb};
      OP_LBU:  ldata_o = {24'd0, rb};
      OP_LH:   ldata_o = {{16{rh[15]}}, rh};
      OP_LHU:  ldata_o = {16'd0, rh};
      default: ldata_o = rdata_i;
    endcase
  end

  // Byte lanes touched by the access.
  always_comb begin
    sel_o = 4'b0000;
    unique case (1'b1)
      sz_b: sel_o = 4'b0001 << lane_i;
      sz_h: sel_o = lane_i[1] ? 4'b1100
                              : 4'b0011;
      sz_w: sel_o = 4'b1111;
      default: sel_o = 4'b0000;
    endcase
  end

  // Replicate store data so every lane sees it.
  always_comb begin
    wdata_o = sdata_i;
    case (op)
      OP_SB:   wdata_o = {4{sdata_i[7:0]}};
      OP_SH:   wdata_o = {2{sdata_i[15:0]}};
      default: wdata_o = sdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage between EX_MEM and MEM_WB.
// Runs req/ack data-bus loads/stores, passes ALU/HILO through.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEMOP_W = 4
) (
  input  logic               cpu_clk_75M,
  input  logic               cpu_rst,
  input  logic [4:0]         mem_wd_i,
  input  logic               mem_wreg_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic               mem_whilo_i,
  input  logic [31:0]        mem_hi_i,
  input  logic [31:0]        mem_lo_i,
  input  logic [MEMOP_W-1:0] mem_op_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [31:0]        mem_sdata_i,
  input  logic [5:0]         stall,
  input  logic               flush,
  output logic [4:0]         mem_wd,
  output logic               mem_wreg,
  output logic [31:0]        mem_wdata,
  output logic               mem_whilo,
  output logic [31:0]        mem_hi,
  output logic [31:0]        mem_lo,
  output logic               stallreq_mem,
  output logic               addr_err,
  output logic [ADDR_W-1:0]  bad_vaddr,
  output logic               dbus_req,
  output logic               dbus_we,
  output logic [3:0]         dbus_sel,
  output logic [ADDR_W-1:0]  dbus_addr,
  output logic [31:0]        dbus_wdata,
  input  logic [31:0]        dbus_rdata,
  input  logic               dbus_ack
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [3:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;

  op_info_t            in_info;
  op_info_t            q_info;
  logic                in_mem;
  logic                issue;
  logic [3:0]          al_op;
  logic [1:0]          al_lane;
  logic [31:0]         al_ldata;
  logic [3:0]          al_sel;
  logic [31:0]         al_wdata;
  logic                unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign in_info = decode_op(4'(mem_op_i),
                             mem_addr_i[1:0]);
  assign q_info  = decode_op(op_q, lane_q);
  assign in_mem  = in_info.is_load
                || in_info.is_store;
  assign issue   = (state_q == S_IDLE) && in_mem
                && !in_info.misaligned && !flush;

  assign al_op   = (state_q == S_IDLE)
                 ? 4'(mem_op_i) : op_q;
  assign al_lane = (state_q == S_IDLE)
                 ? mem_addr_i[1:0] : lane_q;

  mem_align u_align (
    .op_i    (al_op),
    .lane_i  (al_lane),
    .rdata_i (rdata_q),
    .sdata_i (mem_sdata_i),
    .ldata_o (al_ldata),
    .sel_o   (al_sel),
    .wdata_o (al_wdata)
  );

  // State and bus registers; reset drops any request at once.
  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= 4'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
    end
  end

  // Next state: issue, wait for ack, present, or drain.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    op_d    = op_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          req_d   = 1'b1;
          we_d    = in_info.is_store;
          sel_d   = al_sel;
          addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          wdata_d = in_info.is_store ? al_wdata : '0;
          op_d    = 4'(mem_op_i);
          lane_d  = mem_addr_i[1:0];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (dbus_ack) begin
          req_d   = 1'b0;
          rdata_d = dbus_rdata;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush || (stall[STALL_MEM] == NOSTOP))
          state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dbus_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage outputs: pass-through unless a bus access owns them.
  always_comb begin
    mem_wd       = mem_wd_i;
    mem_wreg     = mem_wreg_i;
    mem_wdata    = mem_wdata_i;
    mem_whilo    = mem_whilo_i;
    mem_hi       = mem_hi_i;
    mem_lo       = mem_lo_i;
    stallreq_mem = 1'b0;
    addr_err     = 1'b0;
    bad_vaddr    = '0;
    if (cpu_rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
      mem_whilo = 1'b0;
      mem_hi    = 32'd0;
      mem_lo    = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_mem) begin
            mem_wreg = 1'b0;
            if (!flush) begin
              if (in_info.misaligned) begin
                addr_err  = 1'b1;
                bad_vaddr = mem_addr_i;
              end else begin
                stallreq_mem = 1'b1;
              end
            end
          end
        end
        S_ACCESS: begin
          mem_wreg     = 1'b0;
          stallreq_mem = 1'b1;
        end
        S_DONE: begin
          if (q_info.is_load)
            mem_wdata = al_ldata;
          else
            mem_wreg = 1'b0;
        end
        S_DRAIN: mem_wreg = 1'b0;
        default: mem_wreg = 1'b0;
      endcase
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_sel   = sel_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a transaction-level
// model of load extension, byte lanes and alignment.
module tb_mem_access_unit;

  bit          clk;
  logic        cpu_rst = 1'b1;
  logic [4:0]  mem_wd_i = 5'd3;
  logic        mem_wreg_i = 1'b1;
  logic [31:0] mem_wdata_i = 32'h0000FFFF;
  logic        mem_whilo_i = 1'b1;
  logic [31:0] mem_hi_i = 32'h11112222;
  logic [31:0] mem_lo_i = 32'h33334444;
  logic [3:0]  mem_op_i = 4'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_sdata_i = 32'd0;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        stallreq_mem;
  logic        addr_err;
  logic [31:0] bad_vaddr;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata = 32'hDEADBEEF;
  logic        dbus_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  logic [31:0] exp_addr;
  logic [3:0]  exp_sel;
  logic        exp_we;
  logic [31:0] exp_wdata;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .cpu_clk_75M (clk),
    .cpu_rst     (cpu_rst),
    .mem_wd_i    (mem_wd_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_whilo_i (mem_whilo_i),
    .mem_hi_i    (mem_hi_i),
    .mem_lo_i    (mem_lo_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .stall       (stall),
    .flush       (flush),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .stallreq_mem(stallreq_mem),
    .addr_err    (addr_err),
    .bad_vaddr   (bad_vaddr),
    .dbus_req    (dbus_req),
    .dbus_we     (dbus_we),
    .dbus_sel    (dbus_sel),
    .dbus_addr   (dbus_addr),
    .dbus_wdata  (dbus_wdata),
    .dbus_rdata  (dbus_rdata),
    .dbus_ack    (dbus_ack)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sz(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit misal(input logic [3:0] op,
                               input logic [31:0] a);
    int s;
    s = sz(op);
    return (s > 1) && ((a % s) != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op,
                                       input logic [31:0] a);
    int m;
    m = ((1 << sz(op)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op,
                                          input logic [31:0] d);
    case (sz(op))
      1:       return {24'd0, d[7:0]} * 32'h01010101;
      2:       return {16'd0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] r);
    int bits;
    logic [63:0] v;
    bits = 8 * sz(op);
    v = {32'd0, r >> (8 * a[1:0])};
    if (bits < 32) v = v & ((64'd1 << bits) - 64'd1);
    if ((op == 4'd1 || op == 4'd3) && bits < 32
        && v >= (64'd1 << (bits - 1)))
      v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (mon_en && !cpu_rst) begin
      chk("wd_pass", {27'd0, mem_wd}, {27'd0, mem_wd_i});
      chk("hi_pass", mem_hi, mem_hi_i);
      chk("lo_pass", mem_lo, mem_lo_i);
      chk("whilo_pass", {31'd0, mem_whilo}, {31'd0, mem_whilo_i});
      if (dbus_req) begin
        chk("bus_addr", dbus_addr, exp_addr);
        chk("bus_sel", {28'd0, dbus_sel}, {28'd0, exp_sel});
        chk("bus_we", {31'd0, dbus_we}, {31'd0, exp_we});
        if (exp_we) chk("bus_wdata", dbus_wdata, exp_wdata);
      end
      chk("addr_err", {31'd0, addr_err},
          {31'd0, !flush && (is_ld(mem_op_i) || is_st(mem_op_i))
                  && misal(mem_op_i, mem_addr_i)});
      if (addr_err) chk("bad_vaddr", bad_vaddr, mem_addr_i);
      if (mem_op_i == 4'd0) begin
        chk("none_wdata", mem_wdata, mem_wdata_i);
        chk("none_stall", {31'd0, stallreq_mem}, 32'd0);
      end
    end
  end

  task automatic set_bus(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] sd);
    exp_addr  = {a[31:2], 2'b00};
    exp_sel   = m_sel(op, a);
    exp_we    = is_st(op);
    exp_wdata = m_wdata(op, sd);
  endtask

  // Run one aligned access; called at posedge+1 in IDLE.
  task automatic do_op(input string nm,
                       input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] sd,
                       input logic [31:0] rd,
                       input int waits,
                       input int hold,
                       output logic [31:0] got_data,
                       output logic [3:0] got_sel,
                       output logic got_we,
                       output logic [31:0] got_wdata,
                       output logic got_wreg);
    int scnt, wc, held;
    bit done;
    scnt = 0; wc = 0; held = 0; done = 0;
    got_data = 'x; got_sel = 'x; got_we = 'x;
    got_wdata = 'x; got_wreg = 'x;
    set_bus(op, a, sd);
    mem_op_i = op; mem_addr_i = a; mem_sdata_i = sd;
    mem_wreg_i = 1'b1; mem_wd_i = a[4:0];
    mem_wdata_i = 32'hA5A50000 ^ a;
    for (int c = 0; c < 40 && !done; c++) begin
      dbus_ack = dbus_req && (wc == waits);
      dbus_rdata = dbus_ack ? rd : 32'hDEADBEEF;
      if (dbus_req && !dbus_ack) wc++;
      @(negedge clk);
      if (dbus_req) begin
        got_sel = dbus_sel; got_we = dbus_we;
        got_wdata = dbus_wdata;
      end
      if (stallreq_mem) scnt++;
      else if (scnt > 0) begin
        got_data = mem_wdata; got_wreg = mem_wreg;
        chk({nm, "_wreg"}, {31'd0, mem_wreg},
            {31'd0, is_ld(op)});
        chk({nm, "_data"}, mem_wdata,
            is_ld(op) ? m_load(op, a, rd) : mem_wdata_i);
        if (held < hold) begin
          stall = 6'b010000; held++;
        end else begin
          stall = 6'd0; done = 1;
        end
      end
      @(posedge clk); #1;
    end
    dbus_ack = 1'b0;
    chk({nm, "_finished"}, {31'd0, done}, 32'd1);
    chk({nm, "_stall_cycles"}, scnt, 2 + waits);
    chk({nm, "_req_dropped"}, {31'd0, dbus_req}, 32'd0);
    mem_op_i = 4'd0;
  endtask

  logic [31:0] d, wd;
  logic [3:0]  s;
  logic        we, wr;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_we", {31'd0, dbus_we}, 32'd0);
    chk("rst_sel", {28'd0, dbus_sel}, 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_wdata", dbus_wdata, 32'd0);
    chk("rst_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wreg", {31'd0, mem_wreg}, 32'd0);
    chk("rst_mem_hi", mem_hi, 32'd0);
    cpu_rst = 1'b0;
    mon_en = 1;

    mem_op_i = 4'd0; mem_wdata_i = 32'h1234;
    mem_wd_i = 5'd5; mem_wreg_i = 1'b1;
    #2;
    chk("t1_wdata", mem_wdata, 32'h1234);
    chk("t1_wd", {27'd0, mem_wd}, 32'd5);
    chk("t1_wreg", {31'd0, mem_wreg}, 32'd1);
    chk("t1_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("t1_req", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;

    do_op("t2_lb", 4'd1, 32'h103, 32'd0, 32'h80FFFFFF,
          0, 0, d, s, we, wd, wr);
    chk("t2_sel", {28'd0, s}, 32'h8);
    chk("t2_data", d, 32'hFFFFFF80);

    do_op("t3_lhu", 4'd4, 32'h102, 32'd0, 32'hABCD0000,
          3, 0, d, s, we, wd, wr);
    chk("t3_data", d, 32'h0000ABCD);

    do_op("t4_sh", 4'd7, 32'h202, 32'h11115566, 32'd0,
          0, 0, d, s, we, wd, wr);
    chk("t4_we", {31'd0, we}, 32'd1);
    chk("t4_sel", {28'd0, s}, 32'hC);
    chk("t4_wdata", wd, 32'h55665566);
    chk("t4_wreg", {31'd0, wr}, 32'd0);

    mem_op_i = 4'd5; mem_addr_i = 32'h101; mem_wreg_i = 1'b1;
    @(negedge clk);
    chk("t5_err", {31'd0, addr_err}, 32'd1);
    chk("t5_vaddr", bad_vaddr, 32'h101);
    chk("t5_wreg", {31'd0, mem_wreg}, 32'd0);
    chk("t5_stall", {31'd0, stallreq_mem}, 32'd0);
    @(posedge clk); #1;
    chk("t5_no_req", {31'd0, dbus_req}, 32'd0);
    mem_op_i = 4'd0;
    @(posedge clk); #1;

    do_op("lb1", 4'd1, 32'h101, 32'd0, 32'h12345678,
          0, 2, d, s, we, wd, wr);
    chk("lb1_data", d, 32'h00000056);
    do_op("lh0", 4'd3, 32'h100, 32'd0, 32'h1234F00D,
          1, 0, d, s, we, wd, wr);
    chk("lh0_data", d, 32'hFFFFF00D);
    do_op("lbu2", 4'd2, 32'h102, 32'd0, 32'h00FE0000,
          0, 0, d, s, we, wd, wr);
    chk("lbu2_data", d, 32'h000000FE);
    do_op("lw4", 4'd5, 32'h104, 32'd0, 32'hCAFEBABE,
          2, 0, d, s, we, wd, wr);
    do_op("sb1", 4'd6, 32'h301, 32'h000000AB, 32'd0,
          0, 0, d, s, we, wd, wr);
    chk("sb1_sel", {28'd0, s}, 32'h2);
    chk("sb1_wdata", wd, 32'hABABABAB);
    do_op("sw", 4'd8, 32'h400, 32'h01020304, 32'd0,
          1, 0, d, s, we, wd, wr);
    chk("sw_sel", {28'd0, s}, 32'hF);

    set_bus(4'd5, 32'h108, 32'd0);
    mem_op_i = 4'd5; mem_addr_i = 32'h108; mem_wreg_i = 1'b1;
    @(posedge clk); #1;
    chk("t6_req", {31'd0, dbus_req}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_op_i = 4'd0;
    mem_wreg_i = 1'b0; mem_wdata_i = 32'h77;
    @(negedge clk);
    chk("t6_drain_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("t6_drain_req", {31'd0, dbus_req}, 32'd1);
    chk("t6_drain_wreg", {31'd0, mem_wreg}, 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("t6_ack_wreg", {31'd0, mem_wreg}, 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    chk("t6_idle_req", {31'd0, dbus_req}, 32'd0);
    do_op("t6_lw", 4'd5, 32'h10C, 32'd0, 32'h76543210,
          0, 0, d, s, we, wd, wr);
    chk("t6_lw_data", d, 32'h76543210);

    set_bus(4'd5, 32'h110, 32'd0);
    mem_op_i = 4'd5; mem_addr_i = 32'h110;
    @(posedge clk); #1;
    chk("t7_req", {31'd0, dbus_req}, 32'd1);
    #2;
    mon_en = 0;
    cpu_rst = 1'b1;
    #1;
    chk("t7_req_drop", {31'd0, dbus_req}, 32'd0);
    chk("t7_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("t7_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    cpu_rst = 1'b0; mem_op_i = 4'd0;
    mem_wdata_i = 32'h4242; mem_wreg_i = 1'b1;
    dbus_ack = 1'b1; dbus_rdata = 32'h99999999;
    @(negedge clk);
    chk("t7_late_req", {31'd0, dbus_req}, 32'd0);
    chk("t7_late_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("t7_late_wdata", mem_wdata, 32'h4242);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("t7_after_req", {31'd0, dbus_req}, 32'd0);
    chk("t7_after_wdata", mem_wdata, 32'h4242);
    @(posedge clk); #1;
    mon_en = 1;
    do_op("t7_lw", 4'd5, 32'h114, 32'd0, 32'h0BADF00D,
          2, 0, d, s, we, wd, wr);
    chk("t7_lw_data", d, 32'h0BADF00D);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
